dbus_responder: RTL and testbench

- Memory-side responder for the core's data bus. Accepts `dreq` (`dbus_req_t`) and returns `dresp` (`dbus_resp_t`) under the two-phase `addr_ok`/`data_ok` handshake.
- Backed by an internal 64-bit-wide word array with byte-strobe writes.
- Response latency is programmable, so pipeline stall and handshake logic can be exercised against a non-zero-wait memory.
- Sits between the core and the simulation top in place of the external data memory.

---
 rtl/common.sv | 29 ++
 rtl/dbus_responder_pkg.sv | 24 ++
 rtl/dbus_responder_strobe_merge.sv | 18 +
 rtl/dbus_responder.sv | 109 ++++++++++
 tb/tb_dbus_responder.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/common.sv
// Shared data-bus types used by the core, the caches and memory-side responders.
package common;

  typedef logic [63:0] word_t;
  typedef logic [7:0]  strobe_t;

  // Encodes log2 of the access width in bytes.
  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic          valid;
    logic [63:0]   addr;
    msize_t        size;
    strobe_t       strobe;
    word_t         data;
  } dbus_req_t;

  typedef struct packed {
    logic          addr_ok;
    logic          data_ok;
    word_t         data;
  } dbus_resp_t;

endpackage

// File: rtl/dbus_responder_pkg.sv
// Local FSM encoding and alignment helper for dbus_responder.
package dbus_responder_pkg;
  import common::*;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  function automatic logic misaligned(input logic [63:0] addr, input msize_t size);
    logic m;
    m = 1'b0;
    case (size)
      MSIZE1:  m = 1'b0;
      MSIZE2:  m = addr[0];
      MSIZE4:  m = |addr[1:0];
      MSIZE8:  m = |addr[2:0];
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dbus_responder_strobe_merge.sv
// Byte-strobe merge of new write data into an existing 64-bit word.
module strobe_merge
  import common::*;
(
  input  word_t   old_i,
  input  word_t   wdata_i,
  input  strobe_t strobe_i,
  output word_t   merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int unsigned b = 0; b < 8; b++) begin
      if (strobe_i[b]) merged_o[b*8 +: 8] = wdata_i[b*8 +: 8];
    end
  end

endmodule

// File: rtl/dbus_responder.sv
// Data-bus memory responder with programmable response latency.
// Optional misalignment check enabled by defining DBUS_MISALIGN_CHECK_EN.
module dbus_responder
  import common::*;
  import dbus_responder_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned LATENCY   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       err
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(LATENCY + 1);

  word_t          mem [DEPTH];

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  word_t          rdata_q, out_q;
  logic           err_q;

  logic           accept, in_range, mis;
  word_t          off, rd_word, merged;
  logic [IW-1:0]  idx;

  assign off      = dreq.addr - BASE_ADDR;
  assign in_range = (dreq.addr >= BASE_ADDR) && ((off >> 3) < 64'(DEPTH));
  assign idx      = off[IW+2:3];

`ifdef DBUS_MISALIGN_CHECK_EN
  assign mis = misaligned(dreq.addr, dreq.size);
`else
  logic unused_size;
  assign mis         = 1'b0;
  assign unused_size = ^dreq.size;
`endif

  // Gating with reset keeps addr_ok low and blocks array writes while held in reset.
  assign accept  = reset && (state_q == S_IDLE) && dreq.valid;
  assign rd_word = (in_range && !mis) ? mem[idx] : '0;

  strobe_merge u_merge (
    .old_i    (mem[idx]),
    .wdata_i  (dreq.data),
    .strobe_i (dreq.strobe),
    .merged_o (merged)
  );

  always_ff @(posedge clk) begin
    if (accept && in_range && !mis && (dreq.strobe != '0)) mem[idx] <= merged;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (LATENCY > 1) begin
            state_d = S_WAIT;
            cnt_d   = CW'(LATENCY - 1);
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_d == '0) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rdata_q <= rd_word;
        err_q   <= mis;
      end
      if (state_q == S_RESP) out_q <= rdata_q;
    end
  end

  // out_q keeps the last returned word visible outside the response cycle.
  always_comb begin
    dresp         = '0;
    dresp.addr_ok = accept;
    dresp.data_ok = (state_q == S_RESP);
    dresp.data    = (state_q == S_RESP) ? rdata_q : out_q;
    err           = (state_q == S_RESP) && err_q;
  end

endmodule

// File: tb/tb_dbus_responder.sv
// Self-checking bench for dbus_responder against a word-array reference model.
module tb_dbus_responder;
  import common::*;

  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam int unsigned DEP  = 4096;
  localparam int unsigned LAT  = 2;

  logic       clk = 1'b0;
  logic       reset;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  logic       err;

  int checks = 0;
  int errors = 0;

  logic [63:0] mdl [longint unsigned];

  dbus_responder #(.BASE_ADDR(BASE), .DEPTH(DEP), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .dreq  (dreq),
    .dresp (dresp),
    .err   (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: a sparse word array; expected read is the pre-write word.
  function automatic void model(input logic [63:0] a, input logic [2:0] sz,
                                input logic [7:0] st, input logic [63:0] d,
                                output logic [63:0] rd, output logic e);
    longint unsigned ix;
    logic [63:0] w;
    bit in_r, mis;
    in_r = (a >= BASE) && (((a - BASE) / 8) < 64'(DEP));
    mis  = 1'b0;
`ifdef DBUS_MISALIGN_CHECK_EN
    mis  = (a % (64'd1 << sz)) != 64'd0;
`endif
    e  = mis;
    rd = 64'd0;
    if (in_r && !mis) begin
      ix = (a - BASE) / 8;
      w  = mdl.exists(ix) ? mdl[ix] : 64'd0;
      rd = w;
      for (int b = 0; b < 8; b++) if (st[b]) w[b*8 +: 8] = d[b*8 +: 8];
      if (st != 8'h00) mdl[ix] = w;
    end
  endfunction

  task automatic run(input string tag, input logic [63:0] a, input logic [2:0] sz,
                     input logic [7:0] st, input logic [63:0] d);
    logic [63:0] erd, ord;
    logic ee, oe;
    int n;
    bit got;
    model(a, sz, st, d, erd, ee);
    @(negedge clk);
    dreq.valid = 1'b1; dreq.addr = a; dreq.size = msize_t'(sz);
    dreq.strobe = st;  dreq.data = d;
    #1 chk({tag, ".addr_ok"}, 64'(dresp.addr_ok), 64'd1);
    n = 0; got = 0; ord = '0; oe = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      chk({tag, ".addr_ok_busy"}, 64'(dresp.addr_ok), 64'd0);
      if (dresp.data_ok) begin
        got = 1; ord = dresp.data; oe = err;
      end
    end
    dreq.valid = 1'b0;
    chk({tag, ".latency"}, 64'(n), 64'(LAT));
    chk({tag, ".data"}, ord, erd);
    chk({tag, ".err"}, 64'(oe), 64'(ee));
    @(negedge clk);
    chk({tag, ".data_ok_once"}, 64'(dresp.data_ok), 64'd0);
    chk({tag, ".data_hold"}, dresp.data, erd);
    chk({tag, ".err_idle"}, 64'(err), 64'd0);
  endtask

  initial begin
    logic [63:0] a, d, tmp_rd;
    logic [7:0]  st;
    logic        tmp_e;

    reset = 1'b0;
    dreq  = '0;
    repeat (3) begin
      @(negedge clk);
      chk("rst.addr_ok", 64'(dresp.addr_ok), 64'd0);
      chk("rst.data_ok", 64'(dresp.data_ok), 64'd0);
      chk("rst.err",     64'(err),           64'd0);
      chk("rst.data",    dresp.data,         64'd0);
    end
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle.addr_ok", 64'(dresp.addr_ok), 64'd0);
      chk("idle.data_ok", 64'(dresp.data_ok), 64'd0);
      chk("idle.data",    dresp.data,         64'd0);
    end

    for (int i = 0; i < 16; i++)
      run("preload", BASE + 64'(8 * i), 3'd3, 8'hFF, {$urandom, $urandom});
    run("preload_top", BASE + 64'((DEP - 1) * 8), 3'd3, 8'hFF, 64'hA5A5_5A5A_0F0F_F0F0);

    run("wr8", 64'h8000_0008, 3'd3, 8'hFF, 64'h1122_3344_5566_7788);
    run("rd8", 64'h8000_0008, 3'd3, 8'h00, 64'd0);

    run("pre16",  64'h8000_0010, 3'd3, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    run("part16", 64'h8000_0010, 3'd3, 8'h0F, 64'd0);
    run("rd16",   64'h8000_0010, 3'd3, 8'h00, 64'd0);

    run("oor_wr",  64'h7FFF_FFF8, 3'd3, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF);
    run("oor_top", BASE + 64'((DEP - 1) * 8), 3'd3, 8'h00, 64'd0);
    run("oor_w0",  BASE, 3'd3, 8'h00, 64'd0);
    run("oor_rd",  BASE + 64'(DEP * 8), 3'd3, 8'h00, 64'd0);

    run("mis4",    64'h8000_0003, 3'd2, 8'hFF, 64'h0123_4567_89AB_CDEF);
    run("mis4_rd", 64'h8000_0000, 3'd3, 8'h00, 64'd0);
    run("mis1",    64'h8000_0003, 3'd0, 8'h08, 64'h0000_0000_7700_0000);
    run("mis1_rd", 64'h8000_0000, 3'd3, 8'h00, 64'd0);

    // Write abandoned by reset one cycle after acceptance; its array update must stay.
    a = BASE + 64'd24;
    d = 64'hCAFE_F00D_1234_5678;
    model(a, 3'd3, 8'hFF, d, tmp_rd, tmp_e);
    @(negedge clk);
    dreq.valid = 1'b1; dreq.addr = a; dreq.size = MSIZE8; dreq.strobe = 8'hFF; dreq.data = d;
    #1 chk("mrst.addr_ok", 64'(dresp.addr_ok), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("mrst.data_ok_now", 64'(dresp.data_ok), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("mrst.data_ok_rst", 64'(dresp.data_ok), 64'd0);
      chk("mrst.addr_ok_rst", 64'(dresp.addr_ok), 64'd0);
      chk("mrst.data_rst",    dresp.data,         64'd0);
    end
    dreq.valid = 1'b0;
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("mrst.data_ok_after", 64'(dresp.data_ok), 64'd0);
    end
    run("mrst_rd", a, 3'd3, 8'h00, 64'd0);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(7, 0) != 0) begin
        a = BASE + 64'(8 * $urandom_range(15, 0));
        if ($urandom_range(1, 0) == 1) a = a + 64'($urandom_range(7, 0));
      end else begin
        case ($urandom_range(2, 0))
          0:       a = BASE - 64'(8 * $urandom_range(4, 1));
          1:       a = BASE + 64'(DEP * 8) + 64'(8 * $urandom_range(3, 0));
          default: a = 64'hFFFF_FFFF_FFFF_FFF8;
        endcase
      end
      st = ($urandom_range(3, 0) == 0) ? 8'h00 : 8'($urandom);
      run("rand", a, 3'($urandom_range(3, 0)), st, {$urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
